// File: rtl/sdram_pkg.sv
// sdram_pkg: shared FSM encoding and default sizes for the SDRAM read/write buffers
package sdram_pkg;
    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF = 512;
    localparam int ADDR_W_DEF = 20;
    localparam int BURST_LEN_DEF = 256;
    localparam int ADDR_STEP_DEF = BURST_LEN_DEF;
    localparam logic [19:0] ADDR_MAX_DEF = 20'hFFF00;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ = 2'd1;
    localparam logic [1:0] BURST = 2'd2;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: non-fall-through synchronous FIFO with registered count and sticky overflow
module sync_fifo #(
    parameter int DATA_W = 16,
    parameter int AW = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_vld,
    output logic [AW:0]       usedw,
    output logic              empty,
    output logic              full,
    output logic              overflow
);
    logic [DATA_W-1:0] mem [2**AW];
    logic [AW-1:0] wp, rp;
    logic wr_ok, rd_ok;
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;
    assign empty = usedw == '0;
    assign full = usedw[AW];
    always_ff @(posedge clk)
        if (wr_ok) mem[wp] <= wr_data;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            usedw <= '0;
            rd_data <= '0;
            rd_vld <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wp <= wp + 1'b1;
            if (rd_ok) begin
                rd_data <= mem[rp];
                rp <= rp + 1'b1;
            end
            rd_vld <= rd_ok;
            usedw <= usedw + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
            if (wr_en && full) overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/sdram_rd_buf.sv
// sdram_rd_buf: requests SDRAM read bursts while the FIFO has room for one, buffers the returned words
module sdram_rd_buf
    import sdram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW = $clog2(DEPTH),
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(ADDR_MAX_DEF)
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic              rd_en_cfg,
    output logic              rd_trig,
    input  logic              rd_ack,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rfifo_wr_en,
    input  logic [DATA_W-1:0] rfifo_wr_data,
    input  logic              rfifo_rd_en,
    output logic [DATA_W-1:0] rfifo_rd_data,
    output logic              rfifo_rd_vld,
    output logic [AW:0]       rfifo_usedw,
    output logic              rfifo_empty,
    output logic              rfifo_full,
    output logic              overflow
);
    localparam int CW = $clog2(BURST_LEN);
    logic [1:0] state;
    logic [CW-1:0] cnt;
    logic [AW:0] free;
    assign free = (AW+1)'(DEPTH) - rfifo_usedw;
    sync_fifo #(.DATA_W(DATA_W), .AW(AW)) u_fifo (
        .clk(sclk),
        .rst_n(s_rst_n),
        .wr_en(rfifo_wr_en),
        .wr_data(rfifo_wr_data),
        .rd_en(rfifo_rd_en),
        .rd_data(rfifo_rd_data),
        .rd_vld(rfifo_rd_vld),
        .usedw(rfifo_usedw),
        .empty(rfifo_empty),
        .full(rfifo_full),
        .overflow(overflow)
    );
    // Dropped words still count toward the burst so the FSM never stalls waiting for them
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state <= IDLE;
            cnt <= '0;
            rd_addr <= '0;
            rd_trig <= 1'b0;
        end else if (state == IDLE) begin
            if (rd_en_cfg && free >= (AW+1)'(BURST_LEN)) begin
                state <= REQ;
                rd_trig <= 1'b1;
            end
        end else if (state == REQ) begin
            if (rd_ack) begin
                state <= BURST;
                rd_trig <= 1'b0;
            end
        end else if (state == BURST) begin
            if (rfifo_wr_en) begin
                if (cnt == CW'(BURST_LEN - 1)) begin
                    cnt <= '0;
                    rd_addr <= (rd_addr == ADDR_MAX) ? '0 : rd_addr + ADDR_W'(BURST_LEN);
                    state <= IDLE;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end else begin
            state <= IDLE;
            rd_trig <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sdram_rd_buf.sv
// tb_sdram_rd_buf: directed table and sequence checks for the SDRAM read buffer
module tb_sdram_rd_buf;
    logic sclk = 1'b0;
    logic s_rst_n = 1'b0;
    logic rd_en_cfg = 1'b0, rd_ack = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic rd_trig, rd_vld, empty, full, overflow;
    logic [19:0] rd_addr;
    logic [15:0] rd_data;
    logic [9:0] usedw;
    logic d2_trig, d2_vld, d2_empty, d2_full, d2_ovf;
    logic [19:0] d2_addr;
    logic [15:0] d2_data;
    logic [9:0] d2_usedw;
    int checks = 0, errors = 0;

    always #5 sclk = ~sclk;

    sdram_rd_buf dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .rd_en_cfg(rd_en_cfg), .rd_trig(rd_trig),
        .rd_ack(rd_ack), .rd_addr(rd_addr), .rfifo_wr_en(wr_en), .rfifo_wr_data(wr_data),
        .rfifo_rd_en(rd_en), .rfifo_rd_data(rd_data), .rfifo_rd_vld(rd_vld),
        .rfifo_usedw(usedw), .rfifo_empty(empty), .rfifo_full(full), .overflow(overflow)
    );

    // Small wrap address so the wrap-to-zero path is reached after two bursts
    sdram_rd_buf #(.ADDR_MAX(20'h00100)) dut2 (
        .sclk(sclk), .s_rst_n(s_rst_n), .rd_en_cfg(rd_en_cfg), .rd_trig(d2_trig),
        .rd_ack(rd_ack), .rd_addr(d2_addr), .rfifo_wr_en(wr_en), .rfifo_wr_data(wr_data),
        .rfifo_rd_en(rd_en), .rfifo_rd_data(d2_data), .rfifo_rd_vld(d2_vld),
        .rfifo_usedw(d2_usedw), .rfifo_empty(d2_empty), .rfifo_full(d2_full), .overflow(d2_ovf)
    );

    typedef struct {
        logic wr;
        logic [15:0] wd;
        logic rd;
        logic ack;
        logic [9:0] usedw;
        logic vld;
        logic [15:0] data;
        logic empty;
    } vec_t;
    vec_t tbl[8];

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " rd_trig"}, 32'(rd_trig), 0);
        chk({tag, " rd_addr"}, 32'(rd_addr), 0);
        chk({tag, " rd_data"}, 32'(rd_data), 0);
        chk({tag, " rd_vld"}, 32'(rd_vld), 0);
        chk({tag, " usedw"}, 32'(usedw), 0);
        chk({tag, " empty"}, 32'(empty), 1);
        chk({tag, " full"}, 32'(full), 0);
        chk({tag, " overflow"}, 32'(overflow), 0);
    endtask

    task automatic burst(input int base);
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        chk("trig drops after ack", 32'(rd_trig), 0);
        for (int i = 0; i < 256; i++) begin
            wr_en = 1'b1;
            wr_data = 16'(base + i);
            tick();
        end
        wr_en = 1'b0;
    endtask

    initial begin
        tbl[0] = '{0, 16'h0000, 1, 0, 10'd0, 0, 16'h0000, 1};
        tbl[1] = '{1, 16'hAAAA, 1, 1, 10'd1, 0, 16'h0000, 0};
        tbl[2] = '{0, 16'h0000, 1, 0, 10'd0, 1, 16'hAAAA, 1};
        tbl[3] = '{0, 16'h0000, 1, 1, 10'd0, 0, 16'hAAAA, 1};
        tbl[4] = '{1, 16'h1234, 0, 0, 10'd1, 0, 16'hAAAA, 0};
        tbl[5] = '{1, 16'h5678, 1, 0, 10'd1, 1, 16'h1234, 0};
        tbl[6] = '{0, 16'h0000, 0, 0, 10'd1, 0, 16'h1234, 0};
        tbl[7] = '{0, 16'h0000, 1, 0, 10'd0, 1, 16'h5678, 1};

        tick();
        tick();
        chk_reset_outputs("reset");
        s_rst_n = 1'b1;

        // Empty-FIFO corner cases with requests disabled; stray acks must be ignored
        for (int v = 0; v < 8; v++) begin
            wr_en = tbl[v].wr;
            wr_data = tbl[v].wd;
            rd_en = tbl[v].rd;
            rd_ack = tbl[v].ack;
            tick();
            chk($sformatf("vec%0d usedw", v), 32'(usedw), 32'(tbl[v].usedw));
            chk($sformatf("vec%0d rd_vld", v), 32'(rd_vld), 32'(tbl[v].vld));
            chk($sformatf("vec%0d rd_data", v), 32'(rd_data), 32'(tbl[v].data));
            chk($sformatf("vec%0d empty", v), 32'(empty), 32'(tbl[v].empty));
            chk($sformatf("vec%0d rd_trig", v), 32'(rd_trig), 0);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        rd_ack = 1'b0;

        s_rst_n = 1'b0;
        tick();
        s_rst_n = 1'b1;
        rd_en_cfg = 1'b1;
        chk("trig before first edge", 32'(rd_trig), 0);
        tick();
        chk("first trigger", 32'(rd_trig), 1);
        burst(0);
        chk("b1 trig", 32'(rd_trig), 0);
        chk("b1 usedw", 32'(usedw), 256);
        chk("b1 addr", 32'(rd_addr), 32'h00100);
        tick();
        chk("retrigger", 32'(rd_trig), 1);
        burst(256);
        chk("b2 usedw", 32'(usedw), 512);
        chk("b2 full", 32'(full), 1);
        chk("b2 addr", 32'(rd_addr), 32'h00200);
        chk("wrap addr", 32'(d2_addr), 0);
        tick();
        tick();
        tick();
        chk("no third trigger", 32'(rd_trig), 0);

        wr_en = 1'b1;
        wr_data = 16'hDEAD;
        tick();
        wr_en = 1'b0;
        chk("drop overflow", 32'(overflow), 1);
        chk("drop usedw", 32'(usedw), 512);
        tick();
        chk("overflow sticky", 32'(overflow), 1);

        for (int i = 0; i < 256; i++) begin
            rd_en = 1'b1;
            tick();
            chk("drain vld", 32'(rd_vld), 1);
            chk("drain data", 32'(rd_data), 32'(i));
        end
        rd_en = 1'b0;
        chk("half usedw", 32'(usedw), 256);
        chk("trig not yet", 32'(rd_trig), 0);
        tick();
        chk("refill trigger", 32'(rd_trig), 1);
        chk("vld after stop", 32'(rd_vld), 0);

        for (int i = 256; i < 412; i++) begin
            rd_en = 1'b1;
            tick();
            chk("drain2 data", 32'(rd_data), 32'(i));
        end
        rd_en = 1'b0;
        chk("usedw 100", 32'(usedw), 100);
        rd_en = 1'b1;
        wr_en = 1'b1;
        wr_data = 16'hBEEF;
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        chk("rw usedw", 32'(usedw), 100);
        chk("rw data", 32'(rd_data), 412);
        chk("overflow still", 32'(overflow), 1);

        // Reset in the middle of a burst must clear everything without waiting for a clock
        rd_ack = 1'b1;
        tick();
        rd_ack = 1'b0;
        for (int i = 0; i < 100; i++) begin
            wr_en = 1'b1;
            wr_data = 16'(i);
            tick();
        end
        wr_en = 1'b0;
        chk("pre-reset usedw", 32'(usedw), 200);
        #2;
        s_rst_n = 1'b0;
        #1;
        chk_reset_outputs("async reset");
        tick();
        s_rst_n = 1'b1;
        tick();
        chk("post-reset trigger", 32'(rd_trig), 1);
        chk("post-reset addr", 32'(rd_addr), 0);
        chk("post-reset usedw", 32'(usedw), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_rd_buf.md
Name: sdram_rd_buf

Overview:
- Read-side counterpart of the SDRAM write buffer.
- The write buffer raises a trigger when enough data is queued for the SDRAM write module.
- This block raises rd_trig when the read FIFO has room for one full burst, then absorbs the burst words returned by the SDRAM read module.
- It exposes the buffered data to the downstream consumer and advances the SDRAM burst address after each completed burst.
- Single clock domain (SDRAM core clock).

Parameters:
- DATA_W, 16, FIFO word width.
- DEPTH, 512, FIFO depth in words (power of 2).
- AW, 9, log2(DEPTH).
- BURST_LEN, 256, words per SDRAM read burst.
- ADDR_W, 20, width of the word address presented to the SDRAM read module.
- ADDR_MAX, 20'hFFF00, last burst start address; the next step wraps to 0.

Ports:
- sclk, in, 1: core clock, all logic on the rising edge.
- s_rst_n, in, 1: asynchronous active-low reset.
- rd_en_cfg, in, 1: level enable for issuing new burst requests.
- rd_trig, out, 1: burst request to the SDRAM read module.
- rd_ack, in, 1: one-cycle pulse, request accepted.
- rd_addr, out, ADDR_W: start word address of the current or next burst.
- rfifo_wr_en, in, 1: SDRAM read data valid.
- rfifo_wr_data, in, DATA_W: SDRAM read data.
- rfifo_rd_en, in, 1: consumer read strobe.
- rfifo_rd_data, out, DATA_W: FIFO output word (registered).
- rfifo_rd_vld, out, 1: rfifo_rd_data valid this cycle.
- rfifo_usedw, out, AW+1: stored word count, 0..DEPTH.
- rfifo_empty, out, 1: FIFO empty.
- rfifo_full, out, 1: FIFO full.
- overflow, out, 1: sticky flag, a write was dropped.

Behaviour:
- Reset (asynchronous, s_rst_n=0) forces all of the following:
  - rd_trig=0, rd_addr=0, rfifo_rd_data=0, rfifo_rd_vld=0, rfifo_usedw=0, rfifo_empty=1, rfifo_full=0, overflow=0.
  - FSM to IDLE, burst counter to 0, FIFO pointers to 0.
  - Reset mid-burst discards all contents and the in-flight burst; no resumption.
- FIFO:
  - Synchronous and non-fall-through.
  - A write is accepted when rfifo_wr_en=1 and full=0. A write while full is dropped and sets overflow=1, which holds until reset.
  - A read is accepted when rfifo_rd_en=1 and empty=0. The word appears on rfifo_rd_data with rfifo_rd_vld=1 on the next cycle (latency 1).
  - A read while empty is ignored: rd_vld=0 and rd_data holds its last value.
  - Simultaneous accepted read and write: usedw unchanged.
  - Write while empty plus same-cycle rd_en: the read is ignored.
  - Full blocks a write even when a read occurs in the same cycle.
  - Pointers are AW bits and wrap naturally.
  - usedw, empty and full are registered and reflect all accepted operations of the previous edge.
- free = DEPTH - rfifo_usedw, computed as AW+1 bits unsigned.
- FSM:
  - IDLE: if rd_en_cfg=1 and free>=BURST_LEN, go to REQ; rd_trig goes to 1 the next cycle.
  - REQ: rd_trig held at 1 until rd_ack=1, then go to BURST with rd_trig=0 from the next cycle. Deasserting rd_en_cfg in REQ does not retract the request.
  - BURST:
    - Count accepted plus dropped words (every rfifo_wr_en).
    - When rfifo_wr_en=1 and count==BURST_LEN-1: count clears, rd_addr advances by BURST_LEN, and the FSM returns to IDLE.
    - If rd_addr==ADDR_MAX at that point, rd_addr becomes 0.
    - rd_en_cfg is ignored until the burst completes.
  - rfifo_wr_en outside BURST: still written to the FIFO; it does not affect the FSM or the counter.
  - rd_ack outside REQ is ignored.
- Only one burst is outstanding at a time, so with a conforming SDRAM read module overflow never sets.
- Minimum re-request gap: IDLE→REQ takes 1 cycle after the final burst word.

Decomposition:
- Shared package sdram_pkg holds:
  - the FSM state encoding (IDLE, REQ, BURST);
  - the burst length and address-step constants;
  - the default DATA_W, DEPTH and ADDR_W values shared with the write-side buffer.
- One sub-module: sync_fifo (parameterised DATA_W/AW, providing usedw, full, empty and overflow).
- The FSM and address counter live in the top level.

Test Plan:
1. Reset, rd_en_cfg=1 → rd_trig=1 on the 2nd cycle. rd_ack pulse, then 256 rfifo_wr_en words 0..255 → rd_trig=0, usedw=256, rd_addr=0x00100, FSM returns to IDLE and re-triggers; a second burst gives usedw=512, full=1, and no third trigger.
2. With FIFO full, consumer reads 256 words → data 0..255 in order, rd_vld one cycle after each rd_en. When usedw drops to 256, rd_trig reasserts.
3. Force rd_addr to 0xFFF00 and complete a burst → rd_addr=0x00000.
4. Full FIFO plus an extra rfifo_wr_en → word dropped, overflow=1 sticky, usedw stays 512. Simultaneous rd_en and wr_en at usedw=100 → usedw stays 100.
5. rd_en on empty → rd_vld=0, rd_data unchanged. Write and rd_en together on empty → usedw=1, no read.
6. Assert s_rst_n=0 at burst word 100 → all outputs return to their reset values immediately (asynchronously). After release, a fresh trigger occurs with rd_addr=0.
